// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execute stage with built-in ALU-control decode.
//   Logic/arithmetic ops finish in one cycle. Shifts with a non-zero amount iterate in BUSY,
//   SHIFT_STEP bits per cycle. When the macro ALU_MUL_EN is defined, R-type funct 1001 is a
//   shift-add multiply that takes XLEN BUSY cycles. Without the macro that encoding is illegal.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake (alu_op, funct, op_a, op_b)
//   out_valid/out_ready    result handshake (result, zero, illegal), held until out_ready
//   busy                   unit is iterating a shift or multiply
module alu_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [3:0]      funct,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned ShW   = $clog2(XLEN);
  localparam int unsigned CntW  = ShW + 1;
  localparam logic [CntW-1:0] StepC = CntW'(SHIFT_STEP);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu, OpMul, OpIll
  } op_e;
  typedef enum logic [1:0] {ItSll, ItSrl, ItSra, ItMul} iter_e;

  state_e          state_q, state_d;
  iter_e           iter_q, iter_d;
  logic [CntW-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
`endif

  // Decode
  op_e        op;
  logic [3:0] f_eff;
  always_comb begin
    f_eff = funct;
    // I-type ignores funct[3] except to tell SRLI from SRAI
    if (alu_op == 2'b11 && funct[2:0] != 3'b101) f_eff[3] = 1'b0;
    unique case (alu_op)
      2'b00: op = OpAdd;
      2'b01: op = OpSub;
      default: begin
        case (f_eff)
          4'b0000: op = OpAdd;
          4'b1000: op = OpSub;
          4'b0111: op = OpAnd;
          4'b0110: op = OpOr;
          4'b0100: op = OpXor;
          4'b0001: op = OpSll;
          4'b0101: op = OpSrl;
          4'b1101: op = OpSra;
          4'b0010: op = OpSlt;
          4'b0011: op = OpSltu;
`ifdef ALU_MUL_EN
          4'b1001: op = OpMul;
`endif
          default: op = OpIll;
        endcase
      end
    endcase
  end

  // Single-cycle datapath; shifts here only cover shamt == 0
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_shift, is_iter;
  assign shamt    = op_b[ShW-1:0];
  assign is_shift = (op == OpSll) || (op == OpSrl) || (op == OpSra);
  assign is_iter  = (is_shift && shamt != '0) || (op == OpMul);

  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:  alu_res = op_a + op_b;
      OpSub:  alu_res = op_a - op_b;
      OpAnd:  alu_res = op_a & op_b;
      OpOr:   alu_res = op_a | op_b;
      OpXor:  alu_res = op_a ^ op_b;
      OpSll, OpSrl, OpSra: alu_res = op_a;
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_res = '0;
    endcase
  end

  // Iterative step
  logic [CntW-1:0] step;
  logic [CntW-1:0] rem_next;
  logic [XLEN-1:0] iter_res;
  always_comb begin
    step = (rem_q < StepC) ? rem_q : StepC;
    if (iter_q == ItMul) step = CntW'(1);
    rem_next = rem_q - step;
    case (iter_q)
      ItSll:   iter_res = result_q << step;
      ItSrl:   iter_res = result_q >> step;
      ItSra:   iter_res = $signed(result_q) >>> step;
`ifdef ALU_MUL_EN
      ItMul:   iter_res = result_q + (mplier_q[0] ? mcand_q : '0);
`endif
      default: iter_res = result_q;
    endcase
  end

  // Next state
  logic accept;
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    rem_d     = rem_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`endif
    in_ready = !rst && ((state_q == StIdle) || (state_q == StDone && out_ready));
    accept   = in_valid && in_ready;

    case (state_q)
      StBusy: begin
        result_d = iter_res;
        rem_d    = rem_next;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
        if (rem_next == '0) begin
          state_d = StDone;
          zero_d  = (iter_res == '0);
        end
      end
      default: begin
        if (accept) begin
          illegal_d = (op == OpIll);
          if (is_iter) begin
            state_d = StBusy;
            case (op)
              OpSll:   iter_d = ItSll;
              OpSrl:   iter_d = ItSrl;
              OpSra:   iter_d = ItSra;
              default: iter_d = ItMul;
            endcase
            rem_d    = (op == OpMul) ? CntW'(XLEN) : {1'b0, shamt};
            result_d = (op == OpMul) ? '0 : op_a;
`ifdef ALU_MUL_EN
            mcand_d  = op_a;
            mplier_d = op_b;
`endif
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      iter_q    <= ItSll;
      rem_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`endif
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, zero, illegal, busy;
  logic [1:0]  alu_op;
  logic [3:0]  funct;
  logic [31:0] op_a, op_b, result;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .funct(funct), .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge (unit is expected to be ready).
  task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    alu_op = op; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct = 4'h0; op_a = '0; op_b = '0;
    tick(); tick();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++;
    if ({out_valid, busy, zero, illegal} !== 4'b0000)
      $display("FAIL rst_flags got %b want 0000", {out_valid, busy, zero, illegal});
    else n_pass++;
    n_total++;
    if (result !== 32'h0) $display("FAIL rst_result got %h want 0", result); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", in_ready);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  task automatic test_single_cycle();
    vec_t vt[17];
    vt = '{
      '{2'b10, 4'b0000, 32'd5,          32'd7,          32'd12,         1'b0},
      '{2'b01, 4'b0111, 32'hDEADBEEF,   32'hDEADBEEF,   32'h0,          1'b0},
      '{2'b00, 4'b1000, 32'd3,          32'd4,          32'd7,          1'b0},
      '{2'b10, 4'b1000, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0},
      '{2'b10, 4'b0111, 32'hF0,         32'h3C,         32'h30,         1'b0},
      '{2'b10, 4'b0110, 32'hF0,         32'h0F,         32'hFF,         1'b0},
      '{2'b10, 4'b0100, 32'hFF,         32'h0F,         32'hF0,         1'b0},
      '{2'b10, 4'b0010, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0},
      '{2'b10, 4'b0011, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0},
      '{2'b11, 4'b1000, 32'd10,         32'd3,          32'd13,         1'b0},
      '{2'b11, 4'b1111, 32'hF0,         32'h3C,         32'h30,         1'b0},
      '{2'b11, 4'b1110, 32'hF0,         32'h0F,         32'hFF,         1'b0},
      '{2'b11, 4'b1100, 32'hFF,         32'h0F,         32'hF0,         1'b0},
      '{2'b10, 4'b0101, 32'h1234,       32'h20,         32'h1234,       1'b0},
      '{2'b10, 4'b1111, 32'h55,         32'h66,         32'h0,          1'b1},
      '{2'b10, 4'b1010, 32'h55,         32'h66,         32'h0,          1'b1},
      '{2'b11, 4'b1010, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].op, vt[i].f, vt[i].a, vt[i].b);
      n_total++;
      if (result !== vt[i].exp)
        $display("FAIL single[%0d]_result got %h want %h", i, result, vt[i].exp);
      else n_pass++;
      n_total++;
      if ({out_valid, illegal, zero} !== {1'b1, vt[i].ill, vt[i].exp == 32'h0})
        $display("FAIL single[%0d]_flags got %b want %b", i, {out_valid, illegal, zero},
                 {1'b1, vt[i].ill, vt[i].exp == 32'h0});
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL single[%0d]_drop got %b want 0", i, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_sra_busy();
    out_ready = 1'b1;
    drive(2'b10, 4'b1101, 32'h80000000, 32'd4);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({busy, out_valid, in_ready} !== 3'b100)
        $display("FAIL sra_busy[%0d] got %b want 100", i, {busy, out_valid, in_ready});
      else n_pass++;
      // A request and operand change during BUSY must have no effect
      if (i == 0) begin
        in_valid = 1'b1; alu_op = 2'b10; funct = 4'b0000; op_a = 32'h0; op_b = 32'h1;
      end
      if (i == 2) in_valid = 1'b0;
      tick();
    end
    n_total++;
    if ({out_valid, busy} !== 2'b10) $display("FAIL sra_done got %b want 10", {out_valid, busy});
    else n_pass++;
    n_total++;
    if (result !== 32'hF8000000) $display("FAIL sra_result got %h want f8000000", result);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL sra_idle got %b want 0", out_valid); else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          k;
  } svec_t;

  task automatic test_shift_latency();
    svec_t st[5];
    int cnt;
    st = '{
      '{2'b10, 4'b0001, 32'd1,        32'd3,  32'd8,        3},
      '{2'b11, 4'b0101, 32'h100,      32'd4,  32'h10,       4},
      '{2'b11, 4'b1101, 32'hF0000000, 32'd8,  32'hFFF00000, 8},
      '{2'b10, 4'b0101, 32'h80000000, 32'd31, 32'd1,        31},
      '{2'b11, 4'b1001, 32'd1,        32'd2,  32'd4,        2}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(st[i].op, st[i].f, st[i].a, st[i].b);
      cnt = 0;
      while (!out_valid && cnt < 60) begin
        tick();
        cnt++;
      end
      n_total++;
      if (cnt !== st[i].k) $display("FAIL shift[%0d]_latency got %0d want %0d", i, cnt, st[i].k);
      else n_pass++;
      n_total++;
      if (result !== st[i].exp)
        $display("FAIL shift[%0d]_result got %h want %h", i, result, st[i].exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(2'b10, 4'b0111, 32'hF0F0, 32'hFF00);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'hF000})
        $display("FAIL bp_hold[%0d] got v=%b r=%b res=%h want v=1 r=0 res=f000",
                 i, out_valid, in_ready, result);
      else n_pass++;
      if (i == 0) begin
        in_valid = 1'b1; alu_op = 2'b10; funct = 4'b0000; op_a = 32'd1; op_b = 32'd1;
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, result} !== {1'b1, 32'd2})
      $display("FAIL bp_b2b got v=%b res=%h want v=1 res=2", out_valid, result);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL bp_idle got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_mul_encoding();
    int cnt;
    out_ready = 1'b1;
    drive(2'b10, 4'b1001, 32'd6, 32'd7);
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      tick();
      cnt++;
    end
`ifdef ALU_MUL_EN
    n_total++;
    if (cnt !== 32) $display("FAIL mul_latency got %0d want 32", cnt); else n_pass++;
    n_total++;
    if ({illegal, result} !== {1'b0, 32'd42})
      $display("FAIL mul_result got ill=%b res=%h want ill=0 res=2a", illegal, result);
    else n_pass++;
`else
    n_total++;
    if (cnt !== 0) $display("FAIL mul_illegal_latency got %0d want 0", cnt); else n_pass++;
    n_total++;
    if ({illegal, zero, result} !== {1'b1, 1'b1, 32'd0})
      $display("FAIL mul_illegal got ill=%b z=%b res=%h want ill=1 z=1 res=0",
               illegal, zero, result);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_reset_mid_op();
    int seen;
    out_ready = 1'b1;
    drive(2'b10, 4'b0001, 32'd1, 32'd20);
    tick(); tick();
    n_total++;
    if (busy !== 1'b1) $display("FAIL rmid_busy got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL rmid_in_ready got %b want 0", in_ready); else n_pass++;
    tick();
    rst = 1'b0;
    n_total++;
    if ({busy, out_valid, result} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL rmid_state got b=%b v=%b res=%h want b=0 v=0 res=0", busy, out_valid, result);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_total++;
    if (seen !== 0) $display("FAIL rmid_no_valid got %0d want 0", seen); else n_pass++;
    drive(2'b10, 4'b0000, 32'd2, 32'd2);
    n_total++;
    if ({out_valid, result} !== {1'b1, 32'd4})
      $display("FAIL rmid_next_add got v=%b res=%h want v=1 res=4", out_valid, result);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_sra_busy();
    test_shift_latency();
    test_backpressure();
    test_mul_encoding();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
